memory_responder: RTL and testbench

//  Dual-port word memory, the responder end of the CPU's i_/d_ memory interfaces.

---
 rtl/memory_responder.sv | 261 ++++++++++++++++++++++++++
 tb/tb_memory_responder.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Dual-port word memory acting as the responder for the CPU's instruction (i_)
// and data (d_) memory interfaces. Each port runs its own IDLE/BUSY/DONE
// sequencer that waits a fixed latency before pulsing a one-cycle ready strobe.
// Read data appears on the shared inout bus only in the ready cycle.
//
// Request/ready protocol (both ports):
//   The requester raises readM and/or writeM and holds it, with the address
//   and, for writes, the write data on the bus in the first cycle. The port
//   answers with ready high for exactly one cycle, LATENCY cycles after the
//   first request cycle. Dropping the request before ready aborts the access
//   with no side effect. The request level is ignored in the ready cycle; if
//   it is still high in the following cycle, that starts a new access. Read
//   data is valid on the bus only while ready is high. If readM and writeM
//   are both high, the access is a read.
//
// Debug: i_state/d_state expose each port's sequencer state
//   (2'd0 = IDLE, 2'd1 = BUSY, 2'd2 = DONE).

// One port sequencer. It owns the latched op/address/write data and the read
// capture register. The word array itself lives in the top module so both
// ports share it.
module memory_responder_port #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_req,
  input  logic                 write_req,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [WORD_SIZE-1:0] bus_in,
  input  logic [WORD_SIZE-1:0] rd_word,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic                 ready,
  output logic                 drive,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [WORD_SIZE-1:0] wr_data,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Countdown preload. LATENCY is expected in 1..15 so it fits in 4 bits.
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                 state;
  state_t                 state_next;
  logic [3:0]             cnt;
  logic [3:0]             cnt_next;
  logic                   accept;
  logic                   capture;
  logic                   req;
  logic                   op_write;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [WORD_SIZE-1:0]   wdata_q;
  logic [WORD_SIZE-1:0]   rdata_q;

  assign req = read_req | write_req;

  // Next-state and countdown logic for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept   = 1'b1;
          cnt_next = LAT_M1;
          if (LAT_M1 == 4'd0) begin
            state_next = DONE;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          // Requester withdrew: abort without ready or array update.
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        // Exactly one cycle; requests seen here are ignored.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // The read word is sampled on the edge that enters DONE.
  assign capture = (state_next == DONE) && (state != DONE) && !reset;

  // State register and countdown, synchronously reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Request latches and read capture; contents are don't-care while idle.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      op_write <= write_req & ~read_req;
      addr_q   <= address;
      wdata_q  <= bus_in;
    end
    if (capture) begin
      rdata_q <= rd_word;
    end
  end

  // With LATENCY=1 the capture edge is also the accept edge, so the array is
  // addressed straight from the request port while idle.
  assign rd_addr   = (state == IDLE) ? address : addr_q;

  assign ready     = (state == DONE);
  assign drive     = (state == DONE) && !op_write;
  assign rdata     = rdata_q;

  // Commit happens on the edge leaving DONE unless reset kills it.
  assign wr_en     = (state == DONE) && op_write && !reset;
  assign wr_addr   = addr_q;
  assign wr_data   = wdata_q;

  assign state_dbg = state;

endmodule

// Top level: two independent port sequencers sharing one word array.
module memory_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_readM,
  input  logic                 i_writeM,
  input  logic [WORD_SIZE-1:0] i_address,
  inout  wire  [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  inout  wire  [WORD_SIZE-1:0] d_data,
  output logic                 d_ready,
  output logic [1:0]           i_state,
  output logic [1:0]           d_state
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WORD_SIZE-1:0] mem [0:DEPTH-1];

  logic [ADDR_BITS-1:0] i_rd_addr;
  logic [WORD_SIZE-1:0] i_rd_word;
  logic                 i_drive;
  logic [WORD_SIZE-1:0] i_rdata;
  logic                 i_wr_en;
  logic [ADDR_BITS-1:0] i_wr_addr;
  logic [WORD_SIZE-1:0] i_wr_data;

  logic [ADDR_BITS-1:0] d_rd_addr;
  logic [WORD_SIZE-1:0] d_rd_word;
  logic                 d_drive;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_wr_en;
  logic [ADDR_BITS-1:0] d_wr_addr;
  logic [WORD_SIZE-1:0] d_wr_data;

  // Address bits above the array depth are ignored (the array wraps).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_address[WORD_SIZE-1:ADDR_BITS],
                              d_address[WORD_SIZE-1:ADDR_BITS]};

  memory_responder_port #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_BITS(ADDR_BITS),
    .LATENCY  (LATENCY)
  ) u_i_port (
    .clk      (clk),
    .reset    (reset),
    .read_req (i_readM),
    .write_req(i_writeM),
    .address  (i_address[ADDR_BITS-1:0]),
    .bus_in   (i_data),
    .rd_word  (i_rd_word),
    .rd_addr  (i_rd_addr),
    .ready    (i_ready),
    .drive    (i_drive),
    .rdata    (i_rdata),
    .wr_en    (i_wr_en),
    .wr_addr  (i_wr_addr),
    .wr_data  (i_wr_data),
    .state_dbg(i_state)
  );

  memory_responder_port #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_BITS(ADDR_BITS),
    .LATENCY  (LATENCY)
  ) u_d_port (
    .clk      (clk),
    .reset    (reset),
    .read_req (d_readM),
    .write_req(d_writeM),
    .address  (d_address[ADDR_BITS-1:0]),
    .bus_in   (d_data),
    .rd_word  (d_rd_word),
    .rd_addr  (d_rd_addr),
    .ready    (d_ready),
    .drive    (d_drive),
    .rdata    (d_rdata),
    .wr_en    (d_wr_en),
    .wr_addr  (d_wr_addr),
    .wr_data  (d_wr_data),
    .state_dbg(d_state)
  );

  // Array reads feed the capture registers; a write landing on the same edge
  // is not yet visible, so the old word is captured.
  assign i_rd_word = mem[i_rd_addr];
  assign d_rd_word = mem[d_rd_addr];

  // Array writes; the d-port assignment comes last so it wins a same-address
  // collision on the same edge. Contents are not touched by reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
    if (d_wr_en) begin
      mem[d_wr_addr] <= d_wr_data;
    end
  end

  // Bus drivers: only a read in its ready cycle drives, otherwise hi-Z.
  assign i_data = i_drive ? i_rdata : {WORD_SIZE{1'bz}};
  assign d_data = d_drive ? d_rdata : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_memory_responder.sv
// Testbench for memory_responder. Two instances: dut (LATENCY=2) and dut1
// (LATENCY=1). Port index used by the tasks: 0 = dut i, 1 = dut d,
// 2 = dut1 d, 3 = dut1 i (kept idle). A reference memory per instance holds
// what each address should contain after every completed access.
module tb_memory_responder;

  localparam int LAT = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- stimulus signals ----------------
  logic        p_rd   [4];
  logic        p_wr   [4];
  logic [15:0] p_addr [4];
  logic        p_den  [4];
  logic [15:0] p_dval [4];

  wire  [15:0] i_data, d_data, i1_data, d1_data;
  logic        i_ready, d_ready, i1_ready, d1_ready;
  logic [1:0]  i_state, d_state, i1_state, d1_state;

  assign i_data  = p_den[0] ? p_dval[0] : 16'hzzzz;
  assign d_data  = p_den[1] ? p_dval[1] : 16'hzzzz;
  assign d1_data = p_den[2] ? p_dval[2] : 16'hzzzz;
  assign i1_data = p_den[3] ? p_dval[3] : 16'hzzzz;

  memory_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .i_readM(p_rd[0]), .i_writeM(p_wr[0]), .i_address(p_addr[0]),
    .i_data(i_data), .i_ready(i_ready),
    .d_readM(p_rd[1]), .d_writeM(p_wr[1]), .d_address(p_addr[1]),
    .d_data(d_data), .d_ready(d_ready),
    .i_state(i_state), .d_state(d_state)
  );

  memory_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_readM(p_rd[3]), .i_writeM(p_wr[3]), .i_address(p_addr[3]),
    .i_data(i1_data), .i_ready(i1_ready),
    .d_readM(p_rd[2]), .d_writeM(p_wr[2]), .d_address(p_addr[2]),
    .d_data(d1_data), .d_ready(d1_ready),
    .i_state(i1_state), .d_state(d1_state)
  );

  // ---------------- reference model ----------------
  logic [15:0] ref_mem [2][256];

  function automatic int mem_of(int p);
    return (p >= 2) ? 1 : 0;
  endfunction

  function automatic int lat_of(int p);
    return (p >= 2) ? 1 : LAT;
  endfunction

  function automatic logic get_ready(int p);
    case (p)
      0: return i_ready;
      1: return d_ready;
      2: return d1_ready;
      default: return i1_ready;
    endcase
  endfunction

  function automatic logic [15:0] get_bus(int p);
    case (p)
      0: return i_data;
      1: return d_data;
      2: return d1_data;
      default: return i1_data;
    endcase
  endfunction

  // Undriven bus reads as z on a four-state simulator and as 0 on a
  // two-state one; either means nobody is driving.
  function automatic bit released(logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  // ---------------- driver ----------------
  // Runs one access on port p, holding the request until ready. Write data is
  // on the bus only in the first cycle. Checks the bus is released in every
  // non-ready cycle, and in the ready cycle of a pure write.
  task automatic access(input int p, input bit rd, input bit wr,
                        input logic [15:0] a, input logic [15:0] wd,
                        output logic [15:0] rdata, output int lat, output bit got);
    int start;
    rdata = '0;
    lat   = -1;
    got   = 1'b0;
    @(posedge clk); #1;
    p_rd[p]   = rd;
    p_wr[p]   = wr;
    p_addr[p] = a;
    if (wr) begin
      p_dval[p] = wd;
      p_den[p]  = 1'b1;
    end
    start = cyc;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (get_ready(p)) begin
        got   = 1'b1;
        lat   = cyc - start;
        rdata = get_bus(p);
        if (wr && !rd) begin
          checks++;
          if (!released(get_bus(p))) begin
            errors++;
            $display("FAIL bus_release_wr_done port%0d: bus=%h required=z", p, get_bus(p));
          end
        end
      end else if (!(wr && k == 0)) begin
        checks++;
        if (!released(get_bus(p))) begin
          errors++;
          $display("FAIL bus_release port%0d cycle+%0d: bus=%h required=z", p, k, get_bus(p));
        end
      end
      @(posedge clk); #1;
      p_den[p] = 1'b0;
      if (got) begin
        p_rd[p] = 1'b0;
        p_wr[p] = 1'b0;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout port%0d addr=%h: no ready within 20 cycles", p, a);
      p_rd[p] = 1'b0;
      p_wr[p] = 1'b0;
    end
  endtask

  // Complete access plus latency/data checks against the reference model.
  task automatic checked_access(input int p, input bit rd, input bit wr,
                                input logic [15:0] a, input logic [15:0] wd,
                                input string tag);
    logic [15:0] r;
    logic [15:0] exp;
    int          lat;
    bit          got;
    int          m;
    m   = mem_of(p);
    exp = ref_mem[m][a[7:0]];
    access(p, rd, wr, a, wd, r, lat, got);
    checks++;
    if (lat != lat_of(p)) begin
      errors++;
      $display("FAIL %s_latency port%0d: got %0d required %0d", tag, p, lat, lat_of(p));
    end
    if (rd) begin
      checks++;
      if (r !== exp) begin
        errors++;
        $display("FAIL %s_rdata port%0d addr=%h: got %h required %h", tag, p, a, r, exp);
      end
    end else if (wr && got) begin
      ref_mem[m][a[7:0]] = wd;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    for (int p = 0; p < 4; p++) begin
      p_rd[p] = 1'b0; p_wr[p] = 1'b0; p_addr[p] = '0; p_den[p] = 1'b0; p_dval[p] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready: got %b required 0", i_ready); end
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL reset_d_ready: got %b required 0", d_ready); end
    checks++; if (d1_ready !== 1'b0) begin errors++; $display("FAIL reset_d1_ready: got %b required 0", d1_ready); end
    checks++; if (i_state !== ST_IDLE) begin errors++; $display("FAIL reset_i_state: got %0d required %0d", i_state, ST_IDLE); end
    checks++; if (d_state !== ST_IDLE) begin errors++; $display("FAIL reset_d_state: got %0d required %0d", d_state, ST_IDLE); end
    checks++; if (!released(i_data)) begin errors++; $display("FAIL reset_i_bus: got %h required z", i_data); end
    checks++; if (!released(d_data)) begin errors++; $display("FAIL reset_d_bus: got %h required z", d_data); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    checked_access(1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, "wr_beef");
    checked_access(1, 1'b1, 1'b0, 16'h0010, 16'h0000, "rd_beef");
    checked_access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, "rd_beef_i");
  endtask

  // Drop the request in the BUSY cycle: read first, then a write that must
  // leave the array untouched.
  task automatic test_abort();
    for (int op = 0; op < 2; op++) begin
      @(posedge clk); #1;
      p_addr[1] = 16'h0010;
      if (op == 0) p_rd[1] = 1'b1;
      else begin p_wr[1] = 1'b1; p_dval[1] = 16'h5555; p_den[1] = 1'b1; end
      @(posedge clk); #1;
      p_den[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (d_state !== ST_BUSY) begin errors++; $display("FAIL abort_busy op%0d: got %0d required %0d", op, d_state, ST_BUSY); end
      p_rd[1] = 1'b0;
      p_wr[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b0 || d_state !== ST_IDLE) begin
          errors++;
          $display("FAIL abort_idle op%0d cycle%0d: ready=%b state=%0d required ready=0 state=%0d", op, k, d_ready, d_state, ST_IDLE);
        end
      end
      checked_access(1, 1'b1, 1'b0, 16'h0010, 16'h0000, "after_abort");
    end
  endtask

  task automatic test_reset_midwrite();
    // Reset in the BUSY cycle.
    @(posedge clk); #1;
    p_wr[1] = 1'b1; p_addr[1] = 16'h0010; p_dval[1] = 16'h1234; p_den[1] = 1'b1;
    @(posedge clk); #1;
    p_den[1] = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL rst_busy_ready: got %b required 0", d_ready); end
    @(posedge clk); #1;
    reset = 1'b0; p_wr[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (d_ready !== 1'b0 || d_state !== ST_IDLE) begin
        errors++;
        $display("FAIL rst_busy_after cycle%0d: ready=%b state=%0d required ready=0 state=0", k, d_ready, d_state);
      end
    end
    checked_access(1, 1'b1, 1'b0, 16'h0010, 16'h0000, "rst_busy_rd");
    // Reset in the DONE cycle also drops the write.
    @(posedge clk); #1;
    p_wr[1] = 1'b1; p_addr[1] = 16'h0010; p_dval[1] = 16'h7777; p_den[1] = 1'b1;
    @(posedge clk); #1;
    p_den[1] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL rst_done_ready: got %b required 1", d_ready); end
    @(posedge clk); #1;
    reset = 1'b0; p_wr[1] = 1'b0;
    checked_access(1, 1'b1, 1'b0, 16'h0010, 16'h0000, "rst_done_rd");
  endtask

  task automatic test_same_edge();
    logic [15:0] r0, r1;
    int          l0, l1;
    bit          g0, g1;
    fork
      access(0, 1'b0, 1'b1, 16'h0020, 16'h1111, r0, l0, g0);
      access(1, 1'b0, 1'b1, 16'h0020, 16'h2222, r1, l1, g1);
    join
    checks++;
    if (l0 != LAT || l1 != LAT) begin errors++; $display("FAIL same_edge_latency: got %0d/%0d required %0d", l0, l1, LAT); end
    ref_mem[0][8'h20] = 16'h2222;
    checked_access(0, 1'b1, 1'b0, 16'h0020, 16'h0000, "same_edge_rd");
    // d write commits on the same edge an i read captures: old data returned.
    checked_access(1, 1'b0, 1'b1, 16'h0030, 16'h3333, "pre_wr30");
    fork
      access(1, 1'b0, 1'b1, 16'h0030, 16'h4444, r1, l1, g1);
      begin
        @(posedge clk);
        access(0, 1'b1, 1'b0, 16'h0030, 16'h0000, r0, l0, g0);
      end
    join
    checks++;
    if (r0 !== 16'h3333) begin errors++; $display("FAIL cross_port_old: got %h required %h", r0, 16'h3333); end
    ref_mem[0][8'h30] = 16'h4444;
    checked_access(0, 1'b1, 1'b0, 16'h0030, 16'h0000, "cross_port_new");
  endtask

  // Request held high: ready every LAT+1 cycles, first one LAT cycles in.
  task automatic test_back_to_back();
    bit exp_rdy;
    @(posedge clk); #1;
    p_rd[0] = 1'b1; p_addr[0] = 16'h0010;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_rdy = (k >= LAT) && (((k - LAT) % (LAT + 1)) == 0);
      checks++;
      if (i_ready !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_ready cycle%0d: got %b required %b", k, i_ready, exp_rdy);
      end
      if (exp_rdy) begin
        checks++;
        if (i_data !== ref_mem[0][8'h10]) begin
          errors++;
          $display("FAIL b2b_rdata cycle%0d: got %h required %h", k, i_data, ref_mem[0][8'h10]);
        end
      end
    end
    @(posedge clk); #1;
    p_rd[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b0) begin errors++; $display("FAIL b2b_stop: got %b required 0", i_ready); end
  endtask

  task automatic test_wrap();
    checked_access(2, 1'b0, 1'b1, 16'h0005, 16'h00AA, "wrap_wr");
    checked_access(2, 1'b1, 1'b0, 16'h0105, 16'h0000, "wrap_rd");
    checked_access(2, 1'b0, 1'b1, 16'h0207, 16'h0C0D, "wrap_wr2");
    checked_access(2, 1'b1, 1'b0, 16'hFF07, 16'h0000, "wrap_rd2");
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] wd;
    int          p;
    int          op;
    for (int i = 0; i < 8; i++) begin
      wd = 16'($urandom_range(1, 16'hFFFF));
      checked_access(1, 1'b0, 1'b1, 16'(32'h40 + i), wd, "rand_init");
    end
    for (int i = 0; i < 40; i++) begin
      p  = $urandom_range(0, 1);
      op = $urandom_range(0, 2);
      a  = 16'(($urandom_range(0, 255) << 8) | (32'h40 + $urandom_range(0, 7)));
      wd = 16'($urandom_range(1, 16'hFFFF));
      case (op)
        0: checked_access(p, 1'b1, 1'b0, a, wd, "rand_rd");
        1: checked_access(p, 1'b0, 1'b1, a, wd, "rand_wr");
        default: checked_access(p, 1'b1, 1'b1, a, wd, "rand_both");
      endcase
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_abort();
    test_reset_midwrite();
    test_same_edge();
    test_back_to_back();
    test_wrap();
    test_random();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
